oled_i2c_responder: RTL and testbench
=====================================

Name: oled_i2c_responder

Overview:
Synthesizable I2C target that models the SSD1306-style OLED controller driven by oled_ctrl. It receives address, control and command/data bytes, decodes the command set oled_ctrl issues, and holds the display state registers. Data bytes are written to an external GDDRAM framebuffer port. It is used as the bench-side peer of oled_ctrl, and in hardware as an OLED emulator feeding a video path.

Parameters:
CHIP_ADDR, 7'h3C, 7-bit I2C address this block answers to.
COL_BITS, 7, column index width (128 columns).
PAGE_BITS, 3, page index width (8 pages).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
scl_in  input  1  SCL line (asynchronous, open-drain bus).
sda_in  input  1  SDA line (asynchronous, open-drain bus).
sda_oen  output  1  0 = drive SDA low; 1 = release (high-Z).
fb_we  output  1  one-cycle framebuffer write strobe.
fb_addr  output  PAGE_BITS+COL_BITS  write address {page, col}.
fb_wdata  output  8  framebuffer data byte.
disp_on  output  1  set by 0xAF, cleared by 0xAE.
all_on  output  1  set by 0xA5, cleared by 0xA4.
inverse  output  1  set by 0xA7, cleared by 0xA6.
contrast  output  8  value from 0x81 parameter.
charge_pump  output  1  bit 2 of the 0x8D parameter.
cmd_strobe  output  1  one-cycle pulse per completed command opcode byte.
cmd_byte  output  8  last opcode; valid while cmd_strobe is high.
cmd_unknown  output  1  one-cycle pulse for an opcode not in the decoded set.
busy  output  1  high from START to STOP.

Behaviour:
- Reset values: sda_oen=1, fb_we=0, fb_addr=0, fb_wdata=0, disp_on=0, all_on=0, inverse=0, contrast=8'h7F, charge_pump=0, cmd_strobe=0, cmd_byte=0, cmd_unknown=0, busy=0. Internally: mem_mode=2 (page), col range 0..127, page range 0..7, col ptr 0, page ptr 0. Reset mid-transfer aborts it and releases SDA at once.
- Input conditioning: scl_in and sda_in pass through a 2-FF synchronizer. Edges are detected on the synchronized values.
- Bus conditions: START is SDA falling while SCL high; STOP is SDA rising while SCL high. Repeated START re-enters ADDR from any state.
- Bit timing: SDA is sampled on SCL rising edge, MSB first.
- ACK: SDA is driven low from the SCL falling edge after bit 8 until the next SCL falling edge.
- FSM states: IDLE, ADDR, ACK_ADDR, CTRL, ACK_CTRL, BYTE, ACK_BYTE, READ, WAIT_STOP.
  - ADDR: address match with R/W=0 -> ACK, then CTRL. Match with R/W=1 -> ACK, then READ. Mismatch -> no ACK, then WAIT_STOP.
  - CTRL: bit7=Co, bit6=D/C. ACK, then BYTE.
  - BYTE, Co=0: every following byte uses the latched D/C; ACK each byte.
  - BYTE, Co=1: one byte only, then back to CTRL.
  - READ: shift out status byte {1'b0, ~disp_on, 6'b0}, MSB first, changing SDA on SCL falling edge. Master ACK -> resend the status byte. Master NACK -> WAIT_STOP.
- Command decode (D/C=0):
  - 0xAE/AF, 0xA4/A5, 0xA6/A7: no parameters.
  - 0x81: 1 parameter -> contrast.
  - 0x8D: 1 parameter -> charge_pump.
  - 0x20: 1 parameter -> mem_mode = param[1:0]; value 3 is treated as 2.
  - 0x21: 2 parameters -> col start/end; the pointer loads start.
  - 0x22: 2 parameters -> page start/end; the pointer loads start.
  - Any other opcode: cmd_unknown pulse, no parameters consumed.
  - cmd_strobe fires on the opcode byte only, not on parameters. Parameter bytes fire no strobe.
  - A STOP with parameters still pending discards the command and applies no partial update.
- Data (D/C=1):
  - fb_we pulses for 1 clk, 2 clk after the SCL rise of bit 8, with the current {page, col}.
  - Horizontal mode (0): col++. At col_end, col=col_start and page++. At page_end, page wraps to page_start.
  - Vertical mode (1): page++. At page_end, page=page_start and col++. At col_end, col wraps to col_start.
  - Page mode (2): col++. At col_end, col=col_start; page is unchanged.
- Bytes are accepted and ACKed regardless of disp_on.

Test Plan:
- Write addr 0x3C, ctrl 0x00, bytes AF 81 CF -> three ACKs. disp_on=1, contrast=CF, cmd_strobe twice (AF, 81), no strobe for CF.
- Write addr 0x3D -> SDA stays released on the 9th clock. No outputs change and busy stays high until STOP.
- Commands 20 00, 21 7E 7F, 22 06 07, then data 11 22 33 44 5 bytes... -> fb_we at 7E/6, 7F/6, 7E/7, 7F/7, then 7E/6 (wrap).
- Ctrl 0x80 AE, ctrl 0x80 A7, ctrl 0x40, data 55 -> disp_on=0, inverse=1, fb_we once with addr {0,0} and data 55.
- Read addr 0x3C with disp_on=0, master ACKs the first byte then NACKs -> 0x40 returned twice, SDA released afterwards.
- Send 21 05, then STOP -> col range stays 0..127. Also: assert reset while ACK is driven -> sda_oen=1 in the same cycle.

Source files
------------

// File: rtl/oled_i2c_responder.sv
// oled_i2c_responder: SSD1306-style I2C target.
// Decodes the command set, holds display state, writes GDDRAM.
module oled_i2c_responder #(
  parameter logic [6:0] CHIP_ADDR = 7'h3C,
  parameter int COL_BITS = 7,
  parameter int PAGE_BITS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oen,
  output logic fb_we,
  output logic [PAGE_BITS+COL_BITS-1:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic disp_on,
  output logic all_on,
  output logic inverse,
  output logic [7:0] contrast,
  output logic charge_pump,
  output logic cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic cmd_unknown,
  output logic busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, CTRL, ACK_CTRL,
    BYTE, ACK_BYTE, READ, WAIT_STOP
  } state_t;

  localparam logic [COL_BITS-1:0] C1 = 1;
  localparam logic [PAGE_BITS-1:0] P1 = 1;

  state_t state;
  logic [2:0] scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c, sda_s;
  logic [3:0] cnt;
  logic [7:0] sr, rx_byte, op, status;
  logic [6:0] tx;
  logic byte_rx, rw, co, dc, mack;
  logic [1:0] mem_mode, pend;
  logic [COL_BITS-1:0] p0, col, col_s, col_e;
  logic [PAGE_BITS-1:0] page, page_s, page_e;

  // [0] metastable stage, [1] synchronized, [2] previous
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p <= 3'b111;
      sda_p <= 3'b111;
    end else begin
      scl_p <= {scl_p[1:0], scl_in};
      sda_p <= {sda_p[1:0], sda_in};
    end
  end

  assign sda_s    = sda_p[1];
  assign scl_rise = scl_p[1] & ~scl_p[2];
  assign scl_fall = ~scl_p[1] & scl_p[2];
  assign start_c  = scl_p[1] & scl_p[2] & sda_p[2] & ~sda_p[1];
  assign stop_c   = scl_p[1] & scl_p[2] & ~sda_p[2] & sda_p[1];
  assign status   = {1'b0, ~disp_on, 6'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sda_oen     <= 1'b1;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= 8'h00;
      disp_on     <= 1'b0;
      all_on      <= 1'b0;
      inverse     <= 1'b0;
      contrast    <= 8'h7F;
      charge_pump <= 1'b0;
      cmd_strobe  <= 1'b0;
      cmd_byte    <= 8'h00;
      cmd_unknown <= 1'b0;
      busy        <= 1'b0;
      cnt         <= 4'd0;
      sr          <= 8'h00;
      rx_byte     <= 8'h00;
      op          <= 8'h00;
      tx          <= 7'h00;
      byte_rx     <= 1'b0;
      rw          <= 1'b0;
      co          <= 1'b0;
      dc          <= 1'b0;
      mack        <= 1'b0;
      mem_mode    <= 2'd2;
      pend        <= 2'd0;
      p0          <= '0;
      col         <= '0;
      col_s       <= '0;
      col_e       <= '1;
      page        <= '0;
      page_s      <= '0;
      page_e      <= '1;
    end else begin
      fb_we       <= 1'b0;
      cmd_strobe  <= 1'b0;
      cmd_unknown <= 1'b0;
      byte_rx     <= 1'b0;
      if (start_c) begin
        state   <= ADDR;
        cnt     <= 4'd0;
        sda_oen <= 1'b1;
        busy    <= 1'b1;
      end else if (stop_c) begin
        state   <= IDLE;
        sda_oen <= 1'b1;
        busy    <= 1'b0;
        pend    <= 2'd0;
      end else begin
        if (byte_rx && state == BYTE) begin
          if (dc) begin
            fb_we    <= 1'b1;
            fb_addr  <= {page, col};
            fb_wdata <= rx_byte;
            unique case (1'b1)
              mem_mode == 2'd0: begin
                if (col == col_e) begin
                  col  <= col_s;
                  page <= (page == page_e) ? page_s : page + P1;
                end else col <= col + C1;
              end
              mem_mode == 2'd1: begin
                if (page == page_e) begin
                  page <= page_s;
                  col  <= (col == col_e) ? col_s : col + C1;
                end else page <= page + P1;
              end
              default: col <= (col == col_e) ? col_s : col + C1;
            endcase
          end else if (pend != 2'd0) begin
            pend <= 2'd0;
            case (op)
              8'h81: contrast <= rx_byte;
              8'h8D: charge_pump <= rx_byte[2];
              8'h20: mem_mode <= (rx_byte[1:0] == 2'd3) ?
                                 2'd2 : rx_byte[1:0];
              8'h21: begin
                if (pend == 2'd2) begin
                  p0   <= rx_byte[COL_BITS-1:0];
                  pend <= 2'd1;
                end else begin
                  col_s <= p0;
                  col_e <= rx_byte[COL_BITS-1:0];
                  col   <= p0;
                end
              end
              8'h22: begin
                if (pend == 2'd2) begin
                  p0   <= rx_byte[COL_BITS-1:0];
                  pend <= 2'd1;
                end else begin
                  page_s <= p0[PAGE_BITS-1:0];
                  page_e <= rx_byte[PAGE_BITS-1:0];
                  page   <= p0[PAGE_BITS-1:0];
                end
              end
              default: ;
            endcase
          end else begin
            cmd_strobe <= 1'b1;
            cmd_byte   <= rx_byte;
            op         <= rx_byte;
            case (rx_byte)
              8'hAE: disp_on <= 1'b0;
              8'hAF: disp_on <= 1'b1;
              8'hA4: all_on  <= 1'b0;
              8'hA5: all_on  <= 1'b1;
              8'hA6: inverse <= 1'b0;
              8'hA7: inverse <= 1'b1;
              8'h81, 8'h8D, 8'h20: pend <= 2'd1;
              8'h21, 8'h22: pend <= 2'd2;
              default: cmd_unknown <= 1'b1;
            endcase
          end
        end
        if (state inside {ADDR, CTRL, BYTE} && scl_rise) begin
          sr  <= {sr[6:0], sda_s};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            byte_rx <= 1'b1;
            rx_byte <= {sr[6:0], sda_s};
          end
        end
        unique case (state)
          ADDR: if (scl_fall && cnt == 4'd8) begin
            if (sr[7:1] == CHIP_ADDR) begin
              rw      <= sr[0];
              sda_oen <= 1'b0;
              state   <= ACK_ADDR;
            end else state <= WAIT_STOP;
          end
          CTRL: if (scl_fall && cnt == 4'd8) begin
            co      <= sr[7];
            dc      <= sr[6];
            sda_oen <= 1'b0;
            state   <= ACK_CTRL;
          end
          BYTE: if (scl_fall && cnt == 4'd8) begin
            sda_oen <= 1'b0;
            state   <= ACK_BYTE;
          end
          ACK_ADDR: if (scl_fall) begin
            cnt <= 4'd0;
            if (rw) begin
              tx      <= status[6:0];
              sda_oen <= status[7];
              state   <= READ;
            end else begin
              sda_oen <= 1'b1;
              state   <= CTRL;
            end
          end
          ACK_CTRL: if (scl_fall) begin
            sda_oen <= 1'b1;
            cnt     <= 4'd0;
            state   <= BYTE;
          end
          ACK_BYTE: if (scl_fall) begin
            sda_oen <= 1'b1;
            cnt     <= 4'd0;
            state   <= co ? CTRL : BYTE;
          end
          READ: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd8) mack <= ~sda_s;
            end else if (scl_fall) begin
              if (cnt == 4'd9) begin
                if (mack) begin
                  tx      <= status[6:0];
                  sda_oen <= status[7];
                  cnt     <= 4'd0;
                end else begin
                  sda_oen <= 1'b1;
                  state   <= WAIT_STOP;
                end
              end else if (cnt == 4'd8) begin
                sda_oen <= 1'b1;
              end else begin
                tx      <= {tx[5:0], 1'b0};
                sda_oen <= tx[6];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_i2c_responder.sv
// tb_oled_i2c_responder: bit-banged I2C master with a
// transaction-level model of the OLED controller.
`timescale 1ns/1ps
module tb_oled_i2c_responder;
  localparam int Q = 50;

  logic clk = 1'b0;
  logic reset, scl_m, sda_m, sda_bus;
  logic sda_oen, fb_we, disp_on, all_on, inverse;
  logic charge_pump, cmd_strobe, cmd_unknown, busy;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast, cmd_byte;

  int total = 0, bad = 0;
  int m_disp, m_all, m_inv, m_con, m_cp, m_mode;
  int m_cs, m_ce, m_ps, m_pe, m_col, m_page;
  int exp_unk = 0, got_unk = 0, nstb = 0;
  logic [7:0] m_cmd[$];
  logic [7:0] exp_ops[$];
  logic [17:0] exp_fb[$];
  logic [7:0] txq[$];

  assign sda_bus = sda_m & sda_oen;
  always #5 clk = ~clk;

  oled_i2c_responder dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oen(sda_oen), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .disp_on(disp_on), .all_on(all_on),
    .inverse(inverse), .contrast(contrast),
    .charge_pump(charge_pump), .cmd_strobe(cmd_strobe),
    .cmd_byte(cmd_byte), .cmd_unknown(cmd_unknown), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int plen(input logic [7:0] op);
    case (op)
      8'h81, 8'h8D, 8'h20: return 1;
      8'h21, 8'h22: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit known(input logic [7:0] op);
    return op inside {8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                      8'h81, 8'h8D, 8'h20, 8'h21, 8'h22};
  endfunction

  task automatic model_reset();
    m_disp = 0; m_all = 0; m_inv = 0; m_con = 8'h7F; m_cp = 0;
    m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_col = 0; m_page = 0;
    m_cmd.delete();
  endtask

  task automatic model_cmd(input logic [7:0] b);
    logic [7:0] p1, p2;
    if (m_cmd.size() == 0) begin
      exp_ops.push_back(b);
      if (!known(b)) exp_unk++;
      else if (plen(b) == 0) begin
        case (b)
          8'hAE: m_disp = 0;
          8'hAF: m_disp = 1;
          8'hA4: m_all = 0;
          8'hA5: m_all = 1;
          8'hA6: m_inv = 0;
          default: m_inv = 1;
        endcase
      end else m_cmd.push_back(b);
    end else begin
      m_cmd.push_back(b);
      if (m_cmd.size() == plen(m_cmd[0]) + 1) begin
        p1 = m_cmd[1];
        p2 = m_cmd[m_cmd.size()-1];
        case (m_cmd[0])
          8'h81: m_con = p1;
          8'h8D: m_cp = p1[2];
          8'h20: m_mode = (p1 % 4 == 3) ? 2 : p1 % 4;
          8'h21: begin m_cs = p1 % 128; m_ce = p2 % 128; m_col = m_cs; end
          default: begin m_ps = p1 % 8; m_pe = p2 % 8; m_page = m_ps; end
        endcase
        m_cmd.delete();
      end
    end
  endtask

  task automatic model_data(input logic [7:0] b);
    logic [6:0] c;
    logic [2:0] p;
    c = m_col[6:0];
    p = m_page[2:0];
    exp_fb.push_back({p, c, b});
    if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end else m_page = (m_page + 1) % 8;
    end else begin
      if (m_col == m_ce) begin
        m_col = m_cs;
        if (m_mode == 0)
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1; #Q; scl_m = 1; #Q; sda_m = 0; #Q; scl_m = 0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 0; #Q; scl_m = 1; #Q; sda_m = 1; #Q;
  endtask

  task automatic i2c_bit(input logic b);
    sda_m = b; #Q; scl_m = 1; #(2*Q); scl_m = 0; #Q;
  endtask

  task automatic i2c_wr(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    sda_m = 1; #Q; scl_m = 1; #Q; ack = sda_bus; #Q; scl_m = 0; #Q;
  endtask

  task automatic i2c_rd(input bit ack, output logic [7:0] b);
    sda_m = 1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_m = 1; #Q; b[i] = sda_bus; #Q; scl_m = 0; #Q;
    end
    i2c_bit(!ack);
  endtask

  task automatic send(input bit do_stop);
    logic ack;
    bit ectl, co, dc;
    i2c_start();
    i2c_wr(8'h78, ack);
    chk("ack_addr", ack, 0);
    ectl = 1; co = 0; dc = 0;
    foreach (txq[i]) begin
      if (ectl) begin
        co = txq[i][7]; dc = txq[i][6]; ectl = 0;
      end else begin
        if (dc) model_data(txq[i]);
        else model_cmd(txq[i]);
        if (co) ectl = 1;
      end
      i2c_wr(txq[i], ack);
      chk("ack_byte", ack, 0);
    end
    if (do_stop) begin
      i2c_stop();
      m_cmd.delete();
    end
  endtask

  task automatic read_tx(input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    i2c_wr(8'h79, ack);
    chk("ack_rd_addr", ack, 0);
    for (int j = 0; j < n; j++) begin
      i2c_rd(j < n - 1, b);
      chk("rd_status", b, m_disp ? 8'h00 : 8'h40);
    end
    repeat (8) @(posedge clk);
    #1 chk("rd_release", sda_oen, 1);
    i2c_stop();
  endtask

  task automatic chk_state();
    repeat (10) @(posedge clk);
    #1;
    chk("disp_on", disp_on, m_disp);
    chk("all_on", all_on, m_all);
    chk("inverse", inverse, m_inv);
    chk("contrast", contrast, m_con);
    chk("charge_pump", charge_pump, m_cp);
    chk("fb_left", exp_fb.size(), 0);
    chk("ops_left", exp_ops.size(), 0);
    chk("unknown", got_unk, exp_unk);
    chk("busy_idle", busy, 0);
    chk("sda_idle", sda_oen, 1);
    exp_fb.delete();
    exp_ops.delete();
  endtask

  task automatic monitor();
    logic [17:0] e;
    logic [7:0] o;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fb_we) begin
          if (exp_fb.size() == 0) chk("fb_extra", exp_fb.size(), 1);
          else begin
            e = exp_fb.pop_front();
            chk("fb_write", {fb_addr, fb_wdata}, e);
          end
        end
        if (cmd_strobe) begin
          nstb++;
          if (exp_ops.size() == 0) chk("op_extra", exp_ops.size(), 1);
          else begin
            o = exp_ops.pop_front();
            chk("cmd_byte", cmd_byte, o);
          end
        end
        if (cmd_unknown) got_unk++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    scl_m = 1;
    sda_m = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic rand_cmds();
    int n, k, s;
    logic [7:0] b;
    txq = '{8'h00};
    n = $urandom_range(1, 4);
    for (int j = 0; j < n; j++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: txq.push_back($urandom_range(0, 1) ? 8'hAF : 8'hAE);
        1: txq.push_back($urandom_range(0, 1) ? 8'hA5 : 8'hA4);
        2: txq.push_back($urandom_range(0, 1) ? 8'hA7 : 8'hA6);
        3: begin txq.push_back(8'h81); txq.push_back(8'($urandom)); end
        4: begin txq.push_back(8'h8D); txq.push_back(8'($urandom)); end
        5: begin txq.push_back(8'h20); txq.push_back(8'($urandom)); end
        6: begin
          s = $urandom_range(0, 127);
          txq.push_back(8'h21);
          txq.push_back(8'(s));
          txq.push_back(8'($urandom_range(s, (s + 3 > 127) ? 127 : s + 3)));
        end
        7: begin
          s = $urandom_range(0, 7);
          txq.push_back(8'h22);
          txq.push_back(8'(s));
          txq.push_back(8'($urandom_range(s, 7)));
        end
        default: begin
          do b = 8'($urandom); while (known(b));
          txq.push_back(b);
        end
      endcase
    end
    if ($urandom_range(0, 4) == 0 && txq.size() > 2) void'(txq.pop_back());
    send(1);
  endtask

  initial begin
    logic ack;
    reset = 1;
    scl_m = 1;
    sda_m = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda", sda_oen, 1);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_cmd_byte", cmd_byte, 0);
    chk("rst_strobe", cmd_strobe, 0);
    do_reset();
    fork monitor(); join_none
    chk_state();

    txq = '{8'h00, 8'hAF, 8'h81, 8'hCF};
    send(1);
    chk_state();
    chk("n_strobe", nstb, 2);

    i2c_start();
    i2c_wr(8'h7A, ack);
    chk("nack_addr", ack, 1);
    i2c_wr(8'hAE, ack);
    chk("nack_byte", ack, 1);
    chk("busy_foreign", busy, 1);
    i2c_stop();
    chk_state();

    txq = '{8'h00, 8'h20, 8'h00, 8'h21, 8'h7E, 8'h7F,
            8'h22, 8'h06, 8'h07};
    send(1);
    txq = '{8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(1);
    chk_state();

    do_reset();
    txq = '{8'h80, 8'hAE, 8'h80, 8'hA7, 8'h40, 8'h55};
    send(1);
    chk_state();

    read_tx(2);
    chk_state();

    txq = '{8'h00, 8'h21, 8'h05};
    send(1);
    txq = '{8'h40, 8'h66, 8'h77};
    send(1);
    chk_state();

    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(i > 2 && i < 7);
    for (int k = 0; k < 40 && sda_oen; k++) @(posedge clk);
    #1 chk("ack_driven", sda_oen, 0);
    reset = 1;
    #1 chk("rst_release", sda_oen, 1);
    model_reset();
    scl_m = 1; #Q; sda_m = 1; #Q;
    @(negedge clk);
    reset = 0;
    chk_state();

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0, 1: rand_cmds();
        2: begin
          txq = '{8'h40};
          for (int j = $urandom_range(1, 8); j > 0; j--)
            txq.push_back(8'($urandom));
          send(1);
        end
        default: read_tx($urandom_range(1, 3));
      endcase
      chk_state();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
